// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op codes, FSM states and
// small operand helpers used by the top level and its interface.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MUL   = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  localparam int DIV_CNT_W = 6;

  function automatic logic is_mul_op(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Magnitude of a 32-bit operand; 80000000 stays 80000000 (correct as unsigned).
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO unit.
interface hilo_muldiv_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_t     op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, srca, srcb, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/div_iter.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and shift the quotient bit in.
module div_iter (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvs,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_fits;

  // NOTE: every output of a combinational block is assigned on all paths, so no latch is inferred.
  always_comb begin
    w_shift = {i_rem, i_quo[31]};
    w_fits  = (w_shift >= {1'b0, i_dvs});
    w_diff  = w_shift[31:0] - i_dvs;
    o_rem   = w_fits ? w_diff : w_shift[31:0];
    o_quo   = {i_quo[30:0], w_fits};
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Multiplies run through a MUL_STAGES-deep product pipe; divides are restoring.
module hilo_muldiv
  import mdu_pkg::*;
#(
  parameter int MUL_STAGES = 2,
  parameter int DIV_ITERS  = 32
) (
  input  logic            clk,
  input  logic            reset,
  hilo_muldiv_if.slave    bus
);

  localparam logic [DIV_CNT_W-1:0] MUL_CNT_INIT = DIV_CNT_W'(MUL_STAGES - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_CNT_INIT = DIV_CNT_W'(DIV_ITERS - 1);

  mdu_state_t             r_state;
  logic [DIV_CNT_W-1:0]   r_cnt;
  logic [31:0]            r_hi;
  logic [31:0]            r_lo;
  logic                   r_done;

  logic [63:0]            r_mul_pipe [MUL_STAGES];
  logic                   r_mul_lo_only;
  logic [31:0]            r_rem;
  logic [31:0]            r_quo;
  logic [31:0]            r_dvs;
  logic                   r_neg_q;
  logic                   r_neg_r;

  logic                   w_accept;
  logic                   w_mul_signed;
  logic                   w_div_signed;
  logic [63:0]            w_mul_a;
  logic [63:0]            w_mul_b;
  logic [63:0]            w_product;
  logic [63:0]            w_mul_out;
  logic [31:0]            w_rem_nxt;
  logic [31:0]            w_quo_nxt;
  logic [31:0]            w_quo_fix;
  logic [31:0]            w_rem_fix;

  // A same-cycle cancel drops the request, MTHI/MTLO included.
  assign w_accept     = bus.start && !bus.cancel && (r_state == IDLE);
  assign w_mul_signed = (bus.op != OP_MULTU);
  assign w_div_signed = (bus.op == OP_DIV);

  assign w_mul_a   = w_mul_signed ? {{32{bus.srca[31]}}, bus.srca} : {32'd0, bus.srca};
  assign w_mul_b   = w_mul_signed ? {{32{bus.srcb[31]}}, bus.srcb} : {32'd0, bus.srcb};
  assign w_product = w_mul_a * w_mul_b;
  assign w_mul_out = r_mul_pipe[MUL_STAGES-1];

  assign w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;

  div_iter u_div_iter (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // NOTE: datapath registers carry no reset; they are only consumed after the FSM has loaded them.
  always_ff @(posedge clk) begin
    if (w_accept && is_mul_op(bus.op)) begin
      r_mul_pipe[0] <= w_product;
      r_mul_lo_only <= (bus.op == OP_MUL);
    end
    for (int i = 1; i < MUL_STAGES; i++) begin
      r_mul_pipe[i] <= r_mul_pipe[i-1];
    end

    if (w_accept && is_div_op(bus.op)) begin
      r_rem   <= 32'd0;
      r_quo   <= abs32(bus.srca, w_div_signed);
      r_dvs   <= abs32(bus.srcb, w_div_signed);
      r_neg_q <= w_div_signed && (bus.srca[31] ^ bus.srcb[31]);
      r_neg_r <= w_div_signed && bus.srca[31];
    end else if (r_state == DIV) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            unique case (bus.op)
              OP_MTHI: r_hi <= bus.srca;
              OP_MTLO: r_lo <= bus.srca;
              OP_MULT, OP_MULTU, OP_MUL: begin
                r_state <= MUL;
                r_cnt   <= MUL_CNT_INIT;
              end
              OP_DIV, OP_DIVU: begin
                r_state <= DIV;
                r_cnt   <= DIV_CNT_INIT;
              end
              default: ;
            endcase
          end
        end

        MUL: begin
          if (bus.cancel) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            if (!r_mul_lo_only) begin
              r_hi <= w_mul_out[63:32];
            end
            r_lo    <= w_mul_out[31:0];
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        DIV: begin
          if (bus.cancel) begin
            r_state <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        FIX: begin
          if (!bus.cancel) begin
            r_lo   <= w_quo_fix;
            r_hi   <= w_rem_fix;
            r_done <= 1'b1;
          end
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: cycle-accurate latency, results, cancel and reset.
module tb_hilo_muldiv;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hilo_muldiv_if bus();

  hilo_muldiv #(.MUL_STAGES(2), .DIV_ITERS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start is sampled at the next edge; on return the bench sits in cycle k+1.
  task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.cancel = 1'b0;
    bus.op = OP_MULT; bus.srca = 32'd0; bus.srcb = 32'd0;
    step(); step();
    checks++; if (bus.hi !== 32'd0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTLO, 32'h0000_1234, 32'd0);
    checks++; if (bus.lo !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_pre got=%h exp=00001234", bus.lo); end
    bus.cancel = 1'b1;
    issue(OP_MTLO, 32'h0000_BEEF, 32'd0);
    bus.cancel = 1'b0;
    checks++; if (bus.lo !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_cancel got=%h exp=00001234", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mtlo_cancel_busy got=%b exp=0", bus.busy); end
    issue(OP_MTLO, 32'h0000_BEEF, 32'd0);
    checks++; if (bus.lo !== 32'h0000_BEEF) begin failures++; $display("FAIL mtlo got=%h exp=0000beef", bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mtlo_flags busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    issue(OP_MTHI, 32'hCAFE_0001, 32'd0);
    checks++; if (bus.hi !== 32'hCAFE_0001) begin failures++; $display("FAIL mthi got=%h exp=cafe0001", bus.hi); end
  endtask

  task automatic test_mult();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mult_k1 busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    step();
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mult_k2 busy=%b done=%b exp=1/0", bus.busy, bus.done); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL mult_k3 busy=%b done=%b exp=0/1", bus.busy, bus.done); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
      failures++; $display("FAIL mult_val got=%h_%h exp=ffffffff_fffffff1", bus.hi, bus.lo); end
    step();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_multu_mul();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    checks++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001 || bus.done !== 1'b1) begin
      failures++; $display("FAIL multu got=%h_%h done=%b exp=fffffffe_00000001 done=1", bus.hi, bus.lo, bus.done); end
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    issue(OP_MUL, 32'd7, 32'd6);
    step(); step();
    checks++; if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h0000_002A || bus.done !== 1'b1) begin
      failures++; $display("FAIL mul got=%h_%h done=%b exp=12345678_0000002a done=1", bus.hi, bus.lo, bus.done); end
  endtask

  task automatic test_div();
    int bad;
    bad = 0;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    for (int c = 1; c <= 33; c++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL div_busy_window bad_cycles=%0d exp=0", bad); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      failures++; $display("FAIL div_k34 busy=%b done=%b exp=0/1", bus.busy, bus.done); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div_val lo=%h hi=%h exp=fffffffd/ffffffff", bus.lo, bus.hi); end

    issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    repeat (33) step();
    checks++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h0000_0007 || bus.done !== 1'b1) begin
      failures++; $display("FAIL divu_zero lo=%h hi=%h done=%b exp=ffffffff/00000007/1", bus.lo, bus.hi, bus.done); end

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (33) step();
    checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0000_0000) begin
      failures++; $display("FAIL div_ovf lo=%h hi=%h exp=80000000/00000000", bus.lo, bus.hi); end

    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (33) step();
    checks++; if (bus.lo !== 32'd33 || bus.hi !== 32'd1) begin
      failures++; $display("FAIL divu_100_3 lo=%h hi=%h exp=00000021/00000001", bus.lo, bus.hi); end
  endtask

  task automatic test_cancel();
    issue(OP_MTHI, 32'hAAAA_AAAA, 32'd0);
    issue(OP_MTLO, 32'h5555_5555, 32'd0);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    checks++; if (bus.hi !== 32'hAAAA_AAAA || bus.lo !== 32'h5555_5555 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL cancel_idle hi=%h lo=%h busy=%b exp=aaaaaaaa/55555555/0", bus.hi, bus.lo, bus.busy); end
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (4) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL cancel_k6 busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    checks++; if (bus.hi !== 32'hAAAA_AAAA || bus.lo !== 32'h5555_5555) begin
      failures++; $display("FAIL cancel_hilo hi=%h lo=%h exp=aaaaaaaa/55555555", bus.hi, bus.lo); end
    issue(OP_MULT, 32'd3, 32'd4);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL cancel_next_busy got=%b exp=1", bus.busy); end
    step(); step();
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12 || bus.done !== 1'b1) begin
      failures++; $display("FAIL cancel_next_mult hi=%h lo=%h done=%b exp=0/c/1", bus.hi, bus.lo, bus.done); end
  endtask

  task automatic test_back_to_back();
    issue(OP_MULTU, 32'd10, 32'd10);
    step(); step();
    checks++; if (bus.done !== 1'b1 || bus.lo !== 32'd100) begin
      failures++; $display("FAIL b2b_first done=%b lo=%h exp=1/64", bus.done, bus.lo); end
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy=%b exp=1", bus.busy); end
    step(); step();
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd1 || bus.done !== 1'b1) begin
      failures++; $display("FAIL b2b_second hi=%h lo=%h done=%b exp=0/1/1", bus.hi, bus.lo, bus.done); end
  endtask

  task automatic test_reset_mid_div();
    int dones;
    dones = 0;
    issue(OP_MTHI, 32'h0BAD_F00D, 32'd0);
    issue(OP_MTLO, 32'h0000_D00D, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) step();
    reset = 1'b1;
    step();
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_div hi=%h lo=%h busy=%b done=%b exp=0/0/0/0", bus.hi, bus.lo, bus.busy, bus.done); end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
      step();
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL reset_mid_div_quiet bad_cycles=%0d exp=0", dones); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu_mul();
    test_div();
    test_cancel();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the execute-stage ALU and drives its hi/lo inputs, which the ALU uses for mfhi/mflo and mul results.
- Accepts one operation per start pulse: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MUL.
- Raises busy while a result is pending; the hazard unit stalls mfhi/mflo/mul consumers on busy.

Parameters:
- MUL_STAGES, 2, multiplier pipeline register stages; must be >= 1.
- DIV_ITERS, 32, restoring-divider iterations; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch op this cycle; ignored while busy=1.
- op  input  3  operation code (mdu_op_t).
- srca  input  32  rs operand: multiplicand/dividend/MTHI/MTLO source.
- srcb  input  32  rt operand: multiplier/divisor.
- cancel  input  1  exception flush; aborts the in-flight op.
- busy  output  1  op in flight; hi/lo not yet final.
- done  output  1  one-cycle pulse in the first cycle a mul/div result is visible on hi/lo.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset also wins over an in-flight op or a same-cycle start.
- Cycle numbering: start sampled high in cycle k.
- MTHI/MTLO:
  - hi (or lo) = srca, visible from cycle k+1.
  - busy stays 0 and done stays 0.
- MULT/MULTU:
  - 64-bit product, signed or unsigned per op.
  - Product passes through MUL_STAGES registers.
  - busy=1 in cycles k+1..k+MUL_STAGES.
  - {hi,lo} = product, visible from cycle k+MUL_STAGES+1, with done=1 in that cycle.
- MUL: same as MULT, but writes lo = product[31:0] only; hi is unchanged.
- DIV/DIVU:
  - Operands are converted to magnitudes on entry (signed ops only).
  - DIV_ITERS restoring iterations run, one per cycle, then one FIX cycle applies sign correction.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - busy=1 in cycles k+1..k+DIV_ITERS+1.
  - lo=quotient and hi=remainder, visible from k+DIV_ITERS+2, with done=1 in that cycle.
- Divide by zero: no trap. Result is whatever the restoring datapath naturally produces:
  - DIVU: lo=FFFFFFFF, hi=dividend.
  - DIV: the same magnitudes, then sign-corrected.
- Overflow case, DIV 80000000 / FFFFFFFF: lo=80000000, hi=0.
- State machine (mdu_state_t):
  - IDLE: on start with a mul op -> MUL; on start with a div op -> DIV; on MTHI/MTLO -> stay IDLE.
  - MUL: counts MUL_STAGES-1..0; at 0, writes hi/lo and -> IDLE.
  - DIV: counts DIV_ITERS-1..0; at 0 -> FIX.
  - FIX: writes hi/lo and -> IDLE.
- cancel while busy:
  - Returns to IDLE at the next edge.
  - hi/lo keep their pre-op values; done is not pulsed; busy=0 from the next cycle.
- cancel with start in the same cycle: the op is dropped, including MTHI/MTLO.
- cancel while idle: no effect.
- start while busy: ignored; upstream guarantees it is never issued.
- done and a new start in the same cycle are legal; the new op is accepted.

Decomposition:
- mdu_pkg holds:
  - mdu_op_t enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MUL.
  - mdu_state_t enum: IDLE, MUL, DIV, FIX.
  - Localparam DIV_CNT_W=6.
- Sub-module div_iter: one restoring step, combinational.
  - Inputs: partial remainder, quotient shift register, divisor.
  - Outputs: next remainder, next quotient.
  - The top level registers its outputs each DIV cycle.

Test Plan:
- Reset mid-DIV (start DIV, assert reset at k+10) -> hi=0, lo=0, busy=0 next cycle; no done.
- MULT srca=FFFFFFFD (-3), srcb=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1 at k+3; busy high k+1..k+2; done at k+3.
- MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001. MUL 7*6 with hi preloaded via MTHI 12345678 -> lo=0000002A, hi=12345678.
- DIV FFFFFFF9 (-7) / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF at k+34, busy high k+1..k+33.
  - DIVU 00000007 / 00000000 -> lo=FFFFFFFF, hi=00000007.
- Cancel at k+5 of DIVU 100/3 with hi=AAAAAAAA, lo=55555555 -> busy low at k+6, hi/lo unchanged, no done.
  - A new MULT issued at k+6 completes normally.
- MTLO 0000BEEF with cancel=1 -> lo unchanged. MTLO without cancel -> lo=0000BEEF next cycle, busy never asserted.
